snake_game_ctrl: RTL
====================

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter H, default 32, meaning grid width in cells.
REQ-002 SHALL have parameter V, default 32, meaning grid height in cells.
REQ-003 SHALL have parameter STEP_PERIOD, default 25000000, meaning clk cycles per game step (>=4).
REQ-004 SHALL have parameter INIT_LEN, default 8, meaning snake length after start (<= H*V-1).
REQ-005 SHALL use XB=ceil(log2 H), YB=ceil(log2 V), AB=ceil(log2 H*V) for widths below.
REQ-006 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  in  1  level; begins/restarts a game.
REQ-009 SHALL have port dir  in  2  requested direction: 0 right, 1 up, 2 left, 3 down.
REQ-010 SHALL have port dir_valid  in  1  dir qualifier, one-cycle sample.
REQ-011 SHALL have port end_shift  in  1  snake traversal complete pulse.
REQ-012 SHALL have port self_col  in  1  snake self-collision flag.
REQ-013 SHALL have port last_head  in  XB+YB+1  {x[XB-1:0], y[YB-1:0], active}, current head.
REQ-014 SHALL have ports food_x  in  XB  and food_y  in  YB  food cell.
REQ-015 SHALL have port move  out  2  direction driven to snake.
REQ-016 SHALL have port shift  out  1  one-cycle step request to snake.
REQ-017 SHALL have port length  out  AB  snake length to snake.
REQ-018 SHALL have port snake_rst  out  1  one-cycle snake reinitialisation pulse.
REQ-019 SHALL have ports food_req  out  1  one-cycle new-food pulse; score  out  16  foods eaten; game_over  out  1  level; timeout_err  out  1  level.

Function
REQ-020 SHALL implement FSM states IDLE, RUN_WAIT, SHIFT, WAIT_END, CHECK, OVER.
REQ-021 IDLE: on start=1 SHALL pulse snake_rst one cycle, load length=INIT_LEN, score=0, move=0, pending=0, clear step counter, go RUN_WAIT.
REQ-022 RUN_WAIT: step counter SHALL count 0..STEP_PERIOD-1; at terminal count SHALL load move<=pending, register wall_hit, go SHIFT.
REQ-023 wall_hit SHALL be 1 when head x=H-1 and new move=0, y=V-1 and move=1, x=0 and move=2, or y=0 and move=3.
REQ-024 SHIFT SHALL assert shift for exactly one cycle, clear watchdog, go WAIT_END.
REQ-025 WAIT_END SHALL go CHECK on end_shift=1; if no end_shift within H*V+16 cycles SHALL set timeout_err=1 and go OVER.
REQ-026 CHECK (one cycle) SHALL: go OVER if self_col or wall_hit; else if head x,y equal food_x,food_y, increment length (saturate at H*V-1), increment score (saturate at 65535), pulse food_req; then go RUN_WAIT.
REQ-027 OVER SHALL hold game_over=1 and all pulses 0; start=1 SHALL act as REQ-021 and clear game_over, timeout_err.
REQ-028 dir_valid=1 SHALL update pending<=dir unless (dir XOR move)=2 (reversal), which SHALL be ignored; last accepted request before the load wins.
REQ-029 A dir_valid in the same cycle as the move load SHALL be evaluated against the old move and applied at the next step.
REQ-030 start while in RUN_WAIT/SHIFT/WAIT_END/CHECK SHALL be ignored.
REQ-031 shift, food_req, snake_rst SHALL never be high for more than one consecutive cycle.
REQ-032 length SHALL change only in IDLE/OVER restart and CHECK; stable while WAIT_END.

Reset
REQ-033 reset=1 SHALL asynchronously force IDLE, move=0, shift=0, length=INIT_LEN, snake_rst=0, food_req=0, score=0, game_over=0, timeout_err=0, pending=0, counters=0.
REQ-034 Reset deasserted mid-WAIT_END SHALL leave block in IDLE with no shift issued until start.

Verification
REQ-035 STEP_PERIOD=4, start pulse -> snake_rst 1 cycle, shift first high 4 cycles after RUN_WAIT entry, length=8.
REQ-036 move=0, dir=2 dir_valid -> ignored, next move=0; dir=1 then dir=3 before load -> move=3.
REQ-037 head (31,5), move=0, end_shift, self_col=0 -> CHECK goes OVER, game_over=1, score unchanged.
REQ-038 head equals food (10,10) at CHECK -> length 9, score 1, food_req 1 cycle, back to RUN_WAIT.
REQ-039 end_shift withheld H*V+16 cycles -> timeout_err=1, game_over=1; start -> both clear, snake_rst pulse.
REQ-040 reset asserted during SHIFT -> shift low same cycle (asynchronously), all outputs at REQ-033 values.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Snake game step controller.
// Paces the game with a step counter, hands one shift request per step to the
// snake datapath, waits for the traversal to finish, then judges wall/self
// collisions and food pickup. A watchdog ends the game if the traversal never
// completes.
//
// Ports
//   clk, reset           : sole clock, asynchronous active-high reset
//   start                : level, starts a game from IDLE or OVER
//   dir, dir_valid       : direction request (0 right, 1 up, 2 left, 3 down)
//   end_shift            : traversal-complete pulse from the snake
//   self_col             : self-collision flag from the snake
//   last_head            : {x, y, active} of the current head
//   food_x, food_y       : food cell
//   move                 : direction applied on the current step
//   shift                : one-cycle step request
//   length               : snake length
//   snake_rst            : one-cycle snake reinitialisation pulse
//   food_req             : one-cycle request for a new food cell
//   score                : foods eaten, saturating
//   game_over            : level, game ended
//   timeout_err          : level, traversal watchdog expired
module snake_game_ctrl #(
   parameter int unsigned H           = 32,
   parameter int unsigned V           = 32,
   parameter int unsigned STEP_PERIOD = 25000000,
   parameter int unsigned INIT_LEN    = 8,
   localparam int unsigned XB         = $clog2(H),
   localparam int unsigned YB         = $clog2(V),
   localparam int unsigned AB         = $clog2(H * V)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        dir,
   input  logic              dir_valid,
   input  logic              end_shift,
   input  logic              self_col,
   input  logic [XB+YB:0]    last_head,
   input  logic [XB-1:0]     food_x,
   input  logic [YB-1:0]     food_y,
   output logic [1:0]        move,
   output logic              shift,
   output logic [AB-1:0]     length,
   output logic              snake_rst,
   output logic              food_req,
   output logic [15:0]       score,
   output logic              game_over,
   output logic              timeout_err
);

   localparam int unsigned SB       = $clog2(STEP_PERIOD);
   localparam int unsigned WD_LIMIT = H * V + 16;
   localparam int unsigned WB       = $clog2(WD_LIMIT);
   localparam int unsigned MAX_LEN  = H * V - 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN_WAIT = 3'd1,
      SHIFT    = 3'd2,
      WAIT_END = 3'd3,
      CHECK    = 3'd4,
      OVER     = 3'd5
   } state_t;

   state_t          state_q,       state_d;
   logic [SB-1:0]   step_cnt_q,    step_cnt_d;
   logic [WB-1:0]   wd_cnt_q,      wd_cnt_d;
   logic [1:0]      move_q,        move_d;
   logic [1:0]      pending_q,     pending_d;
   logic            wall_hit_q,    wall_hit_d;
   logic            shift_q,       shift_d;
   logic [AB-1:0]   length_q,      length_d;
   logic            snake_rst_q,   snake_rst_d;
   logic            food_req_q,    food_req_d;
   logic [15:0]     score_q,       score_d;
   logic            game_over_q,   game_over_d;
   logic            timeout_err_q, timeout_err_d;

   // Head coordinates; the active bit carries no information for this block.
   logic [XB-1:0]   head_x;
   logic [YB-1:0]   head_y;
   logic            unused_head_active;

   assign head_x             = last_head[XB+YB:YB+1];
   assign head_y             = last_head[YB:1];
   assign unused_head_active = last_head[0];

   // Wall test for the direction about to be loaded, taken at the load cycle.
   logic wall_chk;
   always_comb begin
      wall_chk = 1'b0;
      unique case (pending_q)
         2'd0: wall_chk = (head_x == XB'(H - 1));
         2'd1: wall_chk = (head_y == YB'(V - 1));
         2'd2: wall_chk = (head_x == '0);
         2'd3: wall_chk = (head_y == '0);
         default: wall_chk = 1'b0;
      endcase
   end

   logic food_hit;
   assign food_hit = (head_x == food_x) && (head_y == food_y);

   // Next-state and output logic.
   always_comb begin
      state_d       = state_q;
      step_cnt_d    = step_cnt_q;
      wd_cnt_d      = wd_cnt_q;
      move_d        = move_q;
      pending_d     = pending_q;
      wall_hit_d    = wall_hit_q;
      length_d      = length_q;
      score_d       = score_q;
      game_over_d   = game_over_q;
      timeout_err_d = timeout_err_q;
      shift_d       = 1'b0;
      snake_rst_d   = 1'b0;
      food_req_d    = 1'b0;

      // Requests are judged against the direction currently applied, so a
      // request landing on the load cycle is checked against the old move
      // and only takes effect on the following step.
      if (dir_valid && ((dir ^ move_q) != 2'd2)) begin
         pending_d = dir;
      end

      unique case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d       = RUN_WAIT;
               snake_rst_d   = 1'b1;
               length_d      = AB'(INIT_LEN);
               score_d       = '0;
               move_d        = 2'd0;
               pending_d     = 2'd0;
               step_cnt_d    = '0;
               wd_cnt_d      = '0;
               wall_hit_d    = 1'b0;
               game_over_d   = 1'b0;
               timeout_err_d = 1'b0;
            end
         end

         RUN_WAIT: begin
            if (step_cnt_q == SB'(STEP_PERIOD - 1)) begin
               step_cnt_d = '0;
               move_d     = pending_q;
               wall_hit_d = wall_chk;
               shift_d    = 1'b1;
               state_d    = SHIFT;
            end else begin
               step_cnt_d = step_cnt_q + SB'(1);
            end
         end

         SHIFT: begin
            wd_cnt_d = '0;
            state_d  = WAIT_END;
         end

         WAIT_END: begin
            if (end_shift) begin
               state_d = CHECK;
            end else if (wd_cnt_q == WB'(WD_LIMIT - 1)) begin
               timeout_err_d = 1'b1;
               game_over_d   = 1'b1;
               state_d       = OVER;
            end else begin
               wd_cnt_d = wd_cnt_q + WB'(1);
            end
         end

         CHECK: begin
            if (self_col || wall_hit_q) begin
               game_over_d = 1'b1;
               state_d     = OVER;
            end else begin
               if (food_hit) begin
                  if (length_q != AB'(MAX_LEN)) begin
                     length_d = length_q + AB'(1);
                  end
                  if (score_q != 16'hFFFF) begin
                     score_d = score_q + 16'd1;
                  end
                  food_req_d = 1'b1;
               end
               step_cnt_d = '0;
               state_d    = RUN_WAIT;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         step_cnt_q    <= '0;
         wd_cnt_q      <= '0;
         move_q        <= 2'd0;
         pending_q     <= 2'd0;
         wall_hit_q    <= 1'b0;
         shift_q       <= 1'b0;
         length_q      <= AB'(INIT_LEN);
         snake_rst_q   <= 1'b0;
         food_req_q    <= 1'b0;
         score_q       <= '0;
         game_over_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_cnt_q    <= step_cnt_d;
         wd_cnt_q      <= wd_cnt_d;
         move_q        <= move_d;
         pending_q     <= pending_d;
         wall_hit_q    <= wall_hit_d;
         shift_q       <= shift_d;
         length_q      <= length_d;
         snake_rst_q   <= snake_rst_d;
         food_req_q    <= food_req_d;
         score_q       <= score_d;
         game_over_q   <= game_over_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign move        = move_q;
   assign shift       = shift_q;
   assign length      = length_q;
   assign snake_rst   = snake_rst_q;
   assign food_req    = food_req_q;
   assign score       = score_q;
   assign game_over   = game_over_q;
   assign timeout_err = timeout_err_q;

endmodule
